// File: rtl/edge_event_arbiter.sv
// Edge-event controller: synchronises N_CH async inputs, counts enabled
// rising/falling edges per source and serves them round-robin on one
// valid/ready event port.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sig_in           asynchronous input levels
//   cfg_rise_en      per-channel rising-edge enable
//   cfg_fall_en      per-channel falling-edge enable
//   evt_valid        event presented on evt_ch / evt_rise
//   evt_ready        consumer accepts the event at posedge clk
//   evt_ch           channel of the presented event
//   evt_rise         1 = rising edge, 0 = falling edge
//   ovf              sticky per-channel counter overflow
//   ovf_clr          write-1-clear for ovf
//   busy             output valid or any pending event
module edge_event_arbiter #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_CH-1:0]                           sig_in,
    input  logic [N_CH-1:0]                           cfg_rise_en,
    input  logic [N_CH-1:0]                           cfg_fall_en,
    output logic                                      evt_valid,
    input  logic                                      evt_ready,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] evt_ch,
    output logic                                      evt_rise,
    output logic [N_CH-1:0]                           ovf,
    input  logic [N_CH-1:0]                           ovf_clr,
    output logic                                      busy
);

    localparam int NS   = 2 * N_CH;
    localparam int SW   = $clog2(NS);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW   = $clog2(SYNC_STAGES + 2);

    localparam logic [AW-1:0]    ARM_DONE = AW'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SW-1:0]    PTR_RST  = SW'(NS - 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  prev_q;
    logic [AW-1:0]    arm_q;
    logic             armed;
    logic [N_CH-1:0]  rise_evt;
    logic [N_CH-1:0]  fall_evt;
    logic [CNT_W-1:0] cnt_q [NS];
    logic [NS-1:0]    inc;
    logic [NS-1:0]    en_src;
    logic [NS-1:0]    req;
    logic [NS-1:0]    dec;
    logic [NS-1:0]    sat;
    logic [N_CH-1:0]  ovf_set;
    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    cand;
    logic [SW-1:0]    gnt_idx;
    logic             gnt_found;
    logic             load;

    // Wrap a scan position back into the source range.
    function automatic logic [SW-1:0] wrap(input int v);
        wrap = (v >= NS) ? SW'(v - NS) : SW'(v);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // prev keeps tracking during the arm window so a level held high
    // through reset is already "old" once detection is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_q <= arm_q + AW'(1);
            end
        end
    end

    assign armed = (arm_q == ARM_DONE);

    assign rise_evt = sync_q[SYNC_STAGES-1] & ~prev_q
                    & cfg_rise_en & {N_CH{armed}};
    assign fall_evt = ~sync_q[SYNC_STAGES-1] & prev_q
                    & cfg_fall_en & {N_CH{armed}};

    // Source 2*ch is the rising source, 2*ch+1 the falling one.
    always_comb begin
        inc    = '0;
        en_src = '0;
        for (int c = 0; c < N_CH; c++) begin
            inc[2*c]      = rise_evt[c];
            inc[2*c+1]    = fall_evt[c];
            en_src[2*c]   = cfg_rise_en[c];
            en_src[2*c+1] = cfg_fall_en[c];
        end
    end

    always_comb begin
        req = '0;
        for (int j = 0; j < NS; j++) begin
            req[j] = (cnt_q[j] != '0);
        end
    end

    // Round-robin: first pending source after the last granted one.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NS; k++) begin
            cand = wrap(int'(ptr_q) + k);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign load = !evt_valid || evt_ready;

    always_comb begin
        dec = '0;
        sat = '0;
        for (int j = 0; j < NS; j++) begin
            dec[j] = load && gnt_found && (gnt_idx == SW'(j));
            sat[j] = inc[j] && !dec[j] && (cnt_q[j] == CNT_MAX);
        end
    end

    always_comb begin
        ovf_set = '0;
        for (int c = 0; c < N_CH; c++) begin
            ovf_set[c] = sat[2*c] | sat[2*c+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NS; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NS; j++) begin
                if (!en_src[j]) begin
                    cnt_q[j] <= '0;
                end else if (inc[j] && !dec[j]) begin
                    if (cnt_q[j] != CNT_MAX) begin
                        cnt_q[j] <= cnt_q[j] + CNT_W'(1);
                    end
                end else if (dec[j] && !inc[j]) begin
                    cnt_q[j] <= cnt_q[j] - CNT_W'(1);
                end
            end
        end
    end

    // A new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            ptr_q     <= PTR_RST;
        end else if (load) begin
            if (gnt_found) begin
                evt_valid <= 1'b1;
                evt_ch    <= CH_W'(gnt_idx >> 1);
                evt_rise  <= ~gnt_idx[0];
                ptr_q     <= gnt_idx;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign busy = evt_valid | (|req);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter (N_CH=4, SYNC_STAGES=2, CNT_W=3).
// Drives and samples 1 time unit after each rising clock edge.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig_in;
    logic [3:0] cfg_rise_en;
    logic [3:0] cfg_fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(
        .N_CH(4),
        .SYNC_STAGES(2),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sig_in(sig_in),
        .cfg_rise_en(cfg_rise_en),
        .cfg_fall_en(cfg_fall_en),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_ch(evt_ch),
        .evt_rise(evt_rise),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        sig_in      = 4'b0101;
        cfg_rise_en = 4'hF;
        cfg_fall_en = 4'hF;
        evt_ready   = 1'b0;
        ovf_clr     = 4'h0;
        #12;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", evt_valid);
        end
        checks++;
        if (evt_ch !== 2'd0 || evt_rise !== 1'b0) begin
            errors++;
            $display("FAIL reset_ch got %0d/%b want 0/0", evt_ch, evt_rise);
        end
        checks++;
        if (ovf !== 4'h0) begin
            errors++;
            $display("FAIL reset_ovf got %h want 0", ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_arm_window;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL arm_valid cyc %0d got %b want 0", i, evt_valid);
            end
        end
        checks++;
        if (ovf !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_idle ovf %h busy %b want 0 0", ovf, busy);
        end
        cfg_fall_en = 4'h0;
        sig_in      = 4'h0;
        tick(5);
        cfg_fall_en = 4'hF;
        tick(2);
        checks++;
        if (evt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_quiet valid %b busy %b want 0 0", evt_valid, busy);
        end
    endtask

    task automatic test_single_rise;
        evt_ready = 1'b1;
        sig_in[2] = 1'b1;
        tick(3);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_early got %b want 0", evt_valid);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL rise_evt got %b/%0d/%b want 1/2/1",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_single got %b want 0", evt_valid);
        end
        sig_in[2] = 1'b0;
        tick(4);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b0) begin
            errors++;
            $display("FAIL fall_evt got %b/%0d/%b want 1/2/0",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(2);
    endtask

    task automatic test_round_robin;
        do_reset();
        evt_ready = 1'b0;
        sig_in    = 4'b1011;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
                errors++;
                $display("FAIL rr_stall cyc %0d got %b/%0d want 1/0",
                         i, evt_valid, evt_ch);
            end
            tick(1);
        end
        evt_ready = 1'b1;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL rr_second got %b/%0d/%b want 1/1/1",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL rr_third got %b/%0d/%b want 1/3/1",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_end got %b want 0", evt_valid);
        end
        cfg_fall_en = 4'h0;
        sig_in      = 4'h0;
        tick(5);
        cfg_fall_en = 4'hF;
    endtask

    task automatic test_saturation;
        int n_all;
        int n_ch1;
        cfg_fall_en = 4'h0;
        evt_ready   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sig_in[1] = 1'b1;
            tick(1);
            sig_in[1] = 1'b0;
            tick(1);
        end
        tick(4);
        checks++;
        if (ovf !== 4'b0010) begin
            errors++;
            $display("FAIL sat_ovf got %b want 0010", ovf);
        end
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_head got %b/%0d/%b want 1/1/1",
                     evt_valid, evt_ch, busy);
        end
        n_all     = 0;
        n_ch1     = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (evt_valid === 1'b1) begin
                n_all++;
                if (evt_ch === 2'd1 && evt_rise === 1'b1) begin
                    n_ch1++;
                end
            end
            tick(1);
        end
        checks++;
        if (n_all != 8) begin
            errors++;
            $display("FAIL sat_drain got %0d events want 8", n_all);
        end
        checks++;
        if (n_ch1 != 8) begin
            errors++;
            $display("FAIL sat_drain_ch1 got %0d events want 8", n_ch1);
        end
        checks++;
        if (busy !== 1'b0 || ovf !== 4'b0010) begin
            errors++;
            $display("FAIL sat_idle busy %b ovf %b want 0 0010", busy, ovf);
        end
        ovf_clr = 4'b0010;
        tick(1);
        ovf_clr = 4'h0;
        checks++;
        if (ovf !== 4'h0) begin
            errors++;
            $display("FAIL ovf_clr got %b want 0000", ovf);
        end
        cfg_fall_en = 4'hF;
    endtask

    task automatic test_enable;
        int n;
        cfg_fall_en[0] = 1'b0;
        evt_ready      = 1'b1;
        sig_in[0]      = 1'b1;
        tick(4);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL en_rise got %b/%0d/%b want 1/0/1",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(1);
        sig_in[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (evt_valid === 1'b1) begin
                n++;
            end
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL en_fall_masked got %0d events want 0", n);
        end
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig_in[0] = 1'b1;
            tick(1);
            sig_in[0] = 1'b0;
            tick(1);
        end
        tick(4);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL en_pending got %b/%0d/%b want 1/0/1",
                     evt_valid, evt_ch, busy);
        end
        cfg_rise_en[0] = 1'b0;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL en_held got %b/%b want 1/1", evt_valid, busy);
        end
        evt_ready = 1'b1;
        tick(1);
        checks++;
        if (evt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_cleared valid %b busy %b want 0 0",
                     evt_valid, busy);
        end
        tick(2);
        cfg_rise_en = 4'hF;
        cfg_fall_en = 4'hF;
    endtask

    task automatic test_reset_mid;
        int n;
        cfg_fall_en = 4'h0;
        evt_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_in[3] = 1'b1;
            tick(1);
            sig_in[3] = 1'b0;
            tick(1);
        end
        tick(4);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending got %b/%0d/%b want 1/3/1",
                     evt_valid, evt_ch, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid %b busy %b want 0 0",
                     evt_valid, busy);
        end
        tick(1);
        cfg_fall_en = 4'hF;
        evt_ready   = 1'b1;
        rst_n       = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (evt_valid === 1'b1) begin
                n++;
            end
        end
        checks++;
        if (n != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet got %0d events busy %b want 0 0", n, busy);
        end
        sig_in[3] = 1'b1;
        tick(4);
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL mid_new got %b/%0d/%b want 1/3/1",
                     evt_valid, evt_ch, evt_rise);
        end
        tick(2);
    endtask

    initial begin
        test_reset();
        test_arm_window();
        test_single_rise();
        test_round_robin();
        test_saturation();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
